rng_test_sched: RTL and testbench
=================================

# rng_test_sched

Sequencer that shares one serial candidate-bit source between `NUM_TESTS` statistical test cores, such as the approximate-entropy and random-excursions cores, and collects their verdicts. For each run it:
- clears the selected cores;
- streams exactly `SEQ_LEN` bits to them;
- waits, with a timeout, for every selected core to report;
- emits a one-cycle `done` with per-test results and an AND-combined pass flag.

It sits between the top-level pin interface and the test cores.

## Interface
Parameters:
- `NUM_TESTS`, 2: number of attached test cores.
- `SEQ_LEN`, 128: bits streamed per run, ≥1.
- `TIMEOUT`, 4096: max cycles spent in WAIT, ≥1.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `test_mask` in NUM_TESTS: cores enabled for the run; sampled with `start`.
- `bit_in` in 1: candidate bit from the source.
- `bit_valid` in 1: `bit_in` is valid this cycle.
- `bit_ready` out 1: scheduler accepts a bit this cycle.
- `core_start` out NUM_TESTS: 1-cycle clear pulse to each enabled core.
- `core_bit` out 1: registered shared bit to the cores.
- `core_strobe` out NUM_TESTS: 1-cycle pulse per enabled core, meaning `core_bit` is a new bit.
- `core_valid` in NUM_TESTS: core verdict-ready pulse, i.e. the core's `valid_rsc_dat`.
- `core_is_random` in NUM_TESTS: core verdict, qualified by `core_valid`.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: 1-cycle run-complete pulse.
- `result` out NUM_TESTS: per-core pass bit; 0 for disabled or timed-out cores.
- `pass` out 1: all enabled cores reported `is_random`=1, and no timeout occurred.
- `timeout` out 1: run ended by timeout.

## Operation
States: IDLE, FEED, WAIT, REPORT.

- **IDLE**
  - On `start` with `test_mask`≠0: latch `mask_q`, clear `got_q`/`res_q`/bit counter/timeout counter, drive `core_start`=`test_mask` for one cycle, then go to FEED.
  - On `start` with `test_mask`=0: go to REPORT with `result`=0, `pass`=0, `timeout`=0.
- **FEED**
  - `bit_ready`=1.
  - On `bit_valid & bit_ready`: register `core_bit`←`bit_in`, pulse `core_strobe`=`mask_q` next cycle, increment counter.
  - After the `SEQ_LEN`-th accepted bit, go to WAIT.
- **WAIT**
  - `bit_ready`=0.
  - The timeout counter increments each cycle.
  - When `got_q` covers `mask_q`, go to REPORT.
  - Else, when the counter reaches `TIMEOUT`, set `timeout` and go to REPORT.
- **Verdict capture** (FEED and WAIT):
  - For each i with `core_valid[i] & mask_q[i] & !got_q[i]`: set `got_q[i]`, set `res_q[i]`←`core_is_random[i]`.
  - Repeat valids from a core are ignored.
  - Valids from disabled cores are ignored.
- **REPORT**
  - `done`=1 for one cycle.
  - `result`=`res_q & got_q & mask_q`.
  - `pass`=(`got_q`==`mask_q`) & (`res_q & mask_q`)==`mask_q` & `mask_q`≠0.
  - Return to IDLE.
  - `result`/`pass`/`timeout` hold until the next accepted `start`, which clears them.
- **Widths:** bit counter is $clog2(`SEQ_LEN`+1) bits; timeout counter is $clog2(`TIMEOUT`+1) bits. Neither wraps; both saturate at their terminal state transition.

## Timing
- **Reset:**
  - State is IDLE.
  - `bit_ready`, `core_start`, `core_bit`, `core_strobe`, `busy`, `done`, `result`, `pass`, `timeout`, and all internal registers are 0.
  - Reset mid-run aborts with no `done` and no `core_start`.
- **Start:**
  - `start` at cycle t gives `core_start` and `busy`=1 at t+1.
  - `bit_ready`=1 from t+1.
- **Bit path:**
  - Bit accepted at cycle c gives `core_bit`/`core_strobe` at c+1. Latency is 1 cycle.
  - Back-to-back acceptance gives one bit per cycle.
  - The last accept at c puts the state in WAIT at c+1, with `bit_ready`=0 at c+1.
- **Report:**
  - The final capturing `core_valid` at cycle v gives REPORT and `done` at v+1, and `busy`=0 at v+2.
  - Fastest run: `done` at t+1+`SEQ_LEN`+1 when all verdicts arrive on the first WAIT cycle.
- **Same-cycle tie:** if the last needed `core_valid` arrives in the same cycle the timeout counter reaches `TIMEOUT`, the valid wins and `timeout`=0.
- **Early verdict:** a `core_valid` arriving during FEED is captured. If all verdicts are captured before the last bit, the run still finishes FEED; REPORT follows the first WAIT cycle.
- **Start while busy:** `start` while `busy`=1 is ignored.

## Test plan
- **Basic run:** `SEQ_LEN`=8, mask=2'b11, 8 bits 10110010 on consecutive cycles, both cores return valid/is_random=1 two cycles into WAIT -> `core_strobe`=2'b11 ×8 carrying the same bit order, `done` once, `result`=2'b11, `pass`=1, `timeout`=0.
- **Throttled source and partial mask:** mask=2'b01, `bit_valid` toggling every other cycle, core0 is_random=0, core1 asserts valid -> `core_strobe[1]` never set, `result`=2'b00, `pass`=0; core1 valid ignored.
- **Timeout:** `TIMEOUT`=16, core1 never valid -> `done` exactly 16 WAIT cycles after entry, `timeout`=1, `pass`=0, `result[1]`=0.
- **Tie and duplicates:** core valid in the same cycle the counter hits `TIMEOUT` -> `timeout`=0. A second core valid with is_random flipped -> first verdict kept.
- **Reset mid-FEED after 3 bits:** -> all outputs 0 next cycle. A new `start` -> full `SEQ_LEN` bits re-streamed, counter restarted.
- **Edge starts:** `start` with mask=0 -> `done` at t+1 with `pass`=0. `start` asserted during FEED -> no effect.

Source files
------------

// File: rtl/rng_test_sched_if.sv
// Bundle of the run-control, bit-source and test-core signals around the scheduler.
// The slave modport is the scheduler's view; master is everything around it.
interface rng_test_sched_if #(
    parameter int NUM_TESTS = 2
);
    logic                 start;
    logic [NUM_TESTS-1:0] test_mask;
    logic                 bit_in;
    logic                 bit_valid;
    logic                 bit_ready;
    logic [NUM_TESTS-1:0] core_start;
    logic                 core_bit;
    logic [NUM_TESTS-1:0] core_strobe;
    logic [NUM_TESTS-1:0] core_valid;
    logic [NUM_TESTS-1:0] core_is_random;
    logic                 busy;
    logic                 done;
    logic [NUM_TESTS-1:0] result;
    logic                 pass;
    logic                 timeout;

    modport master (
        output start, test_mask, bit_in, bit_valid, core_valid, core_is_random,
        input  bit_ready, core_start, core_bit, core_strobe, busy, done,
               result, pass, timeout
    );

    modport slave (
        input  start, test_mask, bit_in, bit_valid, core_valid, core_is_random,
        output bit_ready, core_start, core_bit, core_strobe, busy, done,
               result, pass, timeout
    );
endinterface

// File: rtl/rng_test_sched.sv
// Shares one serial candidate-bit stream between several statistical test cores,
// then gathers their verdicts (with a timeout) into a per-core result and a pass flag.
module rng_test_sched #(
    parameter int NUM_TESTS = 2,
    parameter int SEQ_LEN   = 128,
    parameter int TIMEOUT   = 4096
) (
    input  logic           clk,
    input  logic           rst,
    rng_test_sched_if.slave sb
);
    localparam int CW = $clog2(SEQ_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(SEQ_LEN - 1);
    localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FEED, WAIT, REPORT} state_t;

    state_t               state;
    state_t               state_n;
    logic [NUM_TESTS-1:0] mask_q;
    logic [NUM_TESTS-1:0] got_q;
    logic [NUM_TESTS-1:0] res_q;
    logic [NUM_TESTS-1:0] capture;
    logic [NUM_TESTS-1:0] got_n;
    logic [NUM_TESTS-1:0] res_n;
    logic [CW-1:0]        bit_cnt;
    logic [TW-1:0]        tmo_cnt;
    logic                 accept;
    logic                 last_bit;
    logic                 covered;
    logic                 expired;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Verdicts that land this cycle count toward coverage, so a valid on the
    // final WAIT cycle beats the timeout.
    always_comb begin
        state_n      = state;
        accept       = 1'b0;
        capture      = '0;
        sb.bit_ready = (state == FEED);
        sb.busy      = (state != IDLE);
        sb.done      = (state == REPORT);
        if (state == FEED || state == WAIT)
            capture = sb.core_valid & mask_q & ~got_q;
        got_n    = got_q | capture;
        res_n    = (res_q & ~capture) | (capture & sb.core_is_random);
        covered  = (got_n == mask_q);
        expired  = (tmo_cnt == LAST_WAIT);
        last_bit = (bit_cnt == LAST_BIT);
        case (state)
            IDLE: begin
                if (sb.start)
                    state_n = (sb.test_mask != '0) ? FEED : REPORT;
            end
            FEED: begin
                accept = sb.bit_valid;
                if (accept && last_bit) state_n = WAIT;
            end
            WAIT: begin
                if (covered || expired) state_n = REPORT;
            end
            REPORT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q         <= '0;
            got_q          <= '0;
            res_q          <= '0;
            bit_cnt        <= '0;
            tmo_cnt        <= '0;
            sb.core_start  <= '0;
            sb.core_bit    <= 1'b0;
            sb.core_strobe <= '0;
            sb.result      <= '0;
            sb.pass        <= 1'b0;
            sb.timeout     <= 1'b0;
        end else begin
            sb.core_start  <= '0;
            sb.core_strobe <= '0;
            case (state)
                IDLE: begin
                    // An empty mask also lands here and reports all-zero results.
                    if (sb.start) begin
                        mask_q        <= sb.test_mask;
                        got_q         <= '0;
                        res_q         <= '0;
                        bit_cnt       <= '0;
                        tmo_cnt       <= '0;
                        sb.core_start <= sb.test_mask;
                        sb.result     <= '0;
                        sb.pass       <= 1'b0;
                        sb.timeout    <= 1'b0;
                    end
                end
                FEED: begin
                    got_q <= got_n;
                    res_q <= res_n;
                    if (accept) begin
                        sb.core_bit    <= sb.bit_in;
                        sb.core_strobe <= mask_q;
                        bit_cnt        <= bit_cnt + CW'(1);
                    end
                end
                WAIT: begin
                    got_q   <= got_n;
                    res_q   <= res_n;
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (covered || expired) begin
                        sb.result  <= res_n & got_n & mask_q;
                        sb.pass    <= covered && ((res_n & mask_q) == mask_q) && (mask_q != '0);
                        sb.timeout <= !covered;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rng_test_sched.sv
// Directed bench for rng_test_sched with SEQ_LEN=8, TIMEOUT=16 and two cores.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rng_test_sched;
    logic clk;
    logic rst;
    int   check_count;
    int   pass_count;

    rng_test_sched_if #(.NUM_TESTS(2)) bus ();

    rng_test_sched #(
        .NUM_TESTS(2),
        .SEQ_LEN  (8),
        .TIMEOUT  (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sb (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task nextCycle();
        @(posedge clk);
        #1;
    endtask

    task applyStimulus(input logic s, input logic [1:0] m, input logic bv, input logic bi,
                       input logic [1:0] cv, input logic [1:0] cr);
        bus.start          = s;
        bus.test_mask      = m;
        bus.bit_valid      = bv;
        bus.bit_in         = bi;
        bus.core_valid     = cv;
        bus.core_is_random = cr;
    endtask

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Streams 8 back-to-back bits MSB first; optional core verdict at bit index vj.
    task feedBits(input logic [7:0] pat, input logic [1:0] exp_strobe, input int vj,
                  input logic [1:0] cv, input logic [1:0] cr);
        for (int j = 0; j < 8; j++) begin
            bus.bit_valid      = 1'b1;
            bus.bit_in         = pat[7-j];
            bus.core_valid     = (j == vj) ? cv : 2'b00;
            bus.core_is_random = cr;
            nextCycle();
            checkOutput("feed_strobe", bus.core_strobe, exp_strobe);
            checkOutput("feed_core_bit", bus.core_bit, pat[7-j]);
            checkOutput("feed_core_start", bus.core_start, 0);
            checkOutput("feed_bit_ready", bus.bit_ready, (j == 7) ? 0 : 1);
        end
        bus.bit_valid  = 1'b0;
        bus.core_valid = 2'b00;
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;

        // Reset state
        applyStimulus(0, 2'b00, 0, 0, 2'b00, 2'b00);
        rst = 1'b1;
        nextCycle();
        nextCycle();
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_bit_ready", bus.bit_ready, 0);
        checkOutput("rst_core_start", bus.core_start, 0);
        checkOutput("rst_strobe", bus.core_strobe, 0);
        checkOutput("rst_core_bit", bus.core_bit, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_result", bus.result, 0);
        checkOutput("rst_pass", bus.pass, 0);
        checkOutput("rst_timeout", bus.timeout, 0);
        rst = 1'b0;
        $display("[TB] reset checked");

        // Basic run
        applyStimulus(1, 2'b11, 0, 0, 2'b00, 2'b00);
        nextCycle();
        checkOutput("basic_core_start", bus.core_start, 2'b11);
        checkOutput("basic_busy", bus.busy, 1);
        checkOutput("basic_bit_ready", bus.bit_ready, 1);
        applyStimulus(0, 2'b00, 0, 0, 2'b00, 2'b00);
        feedBits(8'b10110010, 2'b11, -1, 2'b00, 2'b00);
        checkOutput("basic_wait_busy", bus.busy, 1);
        nextCycle();
        checkOutput("basic_wait1_done", bus.done, 0);
        checkOutput("basic_wait1_strobe", bus.core_strobe, 0);
        nextCycle();
        checkOutput("basic_wait2_done", bus.done, 0);
        applyStimulus(0, 2'b00, 0, 0, 2'b11, 2'b11);
        nextCycle();
        checkOutput("basic_done", bus.done, 1);
        checkOutput("basic_result", bus.result, 2'b11);
        checkOutput("basic_pass", bus.pass, 1);
        checkOutput("basic_timeout", bus.timeout, 0);
        applyStimulus(0, 2'b00, 0, 0, 2'b00, 2'b00);
        nextCycle();
        checkOutput("basic_done_once", bus.done, 0);
        checkOutput("basic_idle", bus.busy, 0);
        checkOutput("basic_result_hold", bus.result, 2'b11);
        checkOutput("basic_pass_hold", bus.pass, 1);
        $display("[TB] basic run checked");

        // Throttled source, partial mask, core1 valids ignored
        applyStimulus(1, 2'b01, 0, 0, 2'b00, 2'b00);
        nextCycle();
        checkOutput("thr_core_start", bus.core_start, 2'b01);
        applyStimulus(0, 2'b00, 0, 0, 2'b00, 2'b00);
        begin
            logic [7:0] pat2;
            pat2 = 8'b01101001;
            for (int k = 0; k < 16; k++) begin
                bus.bit_valid      = (k % 2 == 0);
                bus.bit_in         = pat2[7 - k/2];
                bus.core_valid     = (k == 5) ? 2'b10 : 2'b00;
                bus.core_is_random = 2'b10;
                nextCycle();
                checkOutput("thr_strobe", bus.core_strobe, (k % 2 == 0) ? 2'b01 : 2'b00);
                if (k % 2 == 0) checkOutput("thr_core_bit", bus.core_bit, pat2[7 - k/2]);
            end
        end
        applyStimulus(0, 2'b00, 0, 0, 2'b00, 2'b00);
        checkOutput("thr_wait_ready", bus.bit_ready, 0);
        checkOutput("thr_wait_done", bus.done, 0);
        applyStimulus(0, 2'b00, 0, 0, 2'b11, 2'b00);
        nextCycle();
        checkOutput("thr_done", bus.done, 1);
        checkOutput("thr_result", bus.result, 2'b00);
        checkOutput("thr_pass", bus.pass, 0);
        checkOutput("thr_timeout", bus.timeout, 0);
        applyStimulus(0, 2'b00, 0, 0, 2'b00, 2'b00);
        nextCycle();
        checkOutput("thr_idle", bus.busy, 0);
        $display("[TB] throttled run checked");

        // Timeout: core0 answers early, core1 never does
        applyStimulus(1, 2'b11, 0, 0, 2'b00, 2'b00);
        nextCycle();
        checkOutput("tmo_core_start", bus.core_start, 2'b11);
        applyStimulus(0, 2'b00, 0, 0, 2'b00, 2'b00);
        feedBits(8'b11001010, 2'b11, 2, 2'b01, 2'b01);
        for (int n = 0; n < 16; n++) begin
            checkOutput("tmo_wait_done", bus.done, 0);
            nextCycle();
        end
        checkOutput("tmo_done", bus.done, 1);
        checkOutput("tmo_timeout", bus.timeout, 1);
        checkOutput("tmo_pass", bus.pass, 0);
        checkOutput("tmo_result", bus.result, 2'b01);
        nextCycle();
        checkOutput("tmo_idle", bus.busy, 0);
        $display("[TB] timeout run checked");

        // Tie on the final WAIT cycle, duplicate verdict ignored
        applyStimulus(1, 2'b11, 0, 0, 2'b00, 2'b00);
        nextCycle();
        applyStimulus(0, 2'b00, 0, 0, 2'b00, 2'b00);
        feedBits(8'b00111100, 2'b11, 1, 2'b01, 2'b01);
        for (int n = 0; n < 16; n++) begin
            if (n == 0)       applyStimulus(0, 2'b00, 0, 0, 2'b01, 2'b00);
            else if (n == 15) applyStimulus(0, 2'b00, 0, 0, 2'b10, 2'b10);
            else              applyStimulus(0, 2'b00, 0, 0, 2'b00, 2'b00);
            checkOutput("tie_wait_done", bus.done, 0);
            nextCycle();
        end
        applyStimulus(0, 2'b00, 0, 0, 2'b00, 2'b00);
        checkOutput("tie_done", bus.done, 1);
        checkOutput("tie_timeout", bus.timeout, 0);
        checkOutput("tie_pass", bus.pass, 1);
        checkOutput("tie_result", bus.result, 2'b11);
        nextCycle();
        $display("[TB] tie/duplicate run checked");

        // Reset mid-FEED after three bits, then a complete fastest run
        applyStimulus(1, 2'b11, 0, 0, 2'b00, 2'b00);
        nextCycle();
        applyStimulus(0, 2'b00, 1, 1, 2'b00, 2'b00);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("mid_strobe", bus.core_strobe, 2'b11);
        applyStimulus(0, 2'b00, 0, 0, 2'b00, 2'b00);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        checkOutput("mid_busy", bus.busy, 0);
        checkOutput("mid_bit_ready", bus.bit_ready, 0);
        checkOutput("mid_strobe_clr", bus.core_strobe, 0);
        checkOutput("mid_core_bit", bus.core_bit, 0);
        checkOutput("mid_core_start", bus.core_start, 0);
        checkOutput("mid_done", bus.done, 0);
        checkOutput("mid_result", bus.result, 0);
        checkOutput("mid_pass", bus.pass, 0);
        applyStimulus(1, 2'b11, 0, 0, 2'b00, 2'b00);
        nextCycle();
        checkOutput("restart_core_start", bus.core_start, 2'b11);
        applyStimulus(0, 2'b00, 0, 0, 2'b00, 2'b00);
        feedBits(8'b10011101, 2'b11, -1, 2'b00, 2'b00);
        applyStimulus(0, 2'b00, 0, 0, 2'b11, 2'b11);
        nextCycle();
        checkOutput("restart_done", bus.done, 1);
        checkOutput("restart_pass", bus.pass, 1);
        applyStimulus(0, 2'b00, 0, 0, 2'b00, 2'b00);
        nextCycle();
        $display("[TB] mid-run reset checked");

        // Empty-mask start, then start pulses during FEED
        applyStimulus(1, 2'b00, 0, 0, 2'b00, 2'b00);
        nextCycle();
        checkOutput("empty_done", bus.done, 1);
        checkOutput("empty_pass", bus.pass, 0);
        checkOutput("empty_result", bus.result, 0);
        checkOutput("empty_timeout", bus.timeout, 0);
        checkOutput("empty_core_start", bus.core_start, 0);
        checkOutput("empty_busy", bus.busy, 1);
        applyStimulus(0, 2'b00, 0, 0, 2'b00, 2'b00);
        nextCycle();
        checkOutput("empty_done_once", bus.done, 0);
        checkOutput("empty_idle", bus.busy, 0);
        applyStimulus(1, 2'b01, 0, 0, 2'b00, 2'b00);
        nextCycle();
        checkOutput("busy_start_core_start", bus.core_start, 2'b01);
        applyStimulus(1, 2'b10, 0, 0, 2'b00, 2'b00);
        feedBits(8'b01010111, 2'b01, -1, 2'b00, 2'b00);
        applyStimulus(0, 2'b00, 0, 0, 2'b01, 2'b01);
        checkOutput("busy_start_wait", bus.busy, 1);
        nextCycle();
        checkOutput("busy_start_done", bus.done, 1);
        checkOutput("busy_start_result", bus.result, 2'b01);
        checkOutput("busy_start_pass", bus.pass, 1);
        applyStimulus(0, 2'b00, 0, 0, 2'b00, 2'b00);
        nextCycle();
        checkOutput("busy_start_idle", bus.busy, 0);
        $display("[TB] edge starts checked");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
